// File: rtl/seq_multiplier_if.sv
// Request/response bundle for the iterative multiplier.
// Handshake: the slave accepts start when it is idle or in its done cycle, capturing
// a and b on that edge. While busy, start is ignored. done pulses for one cycle, and
// product then holds its value until the next accepted start.
interface seq_multiplier_if #(
  parameter int WIDTH = 64
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier that retires one multiplier bit per clock.
// A result appears WIDTH cycles after the accepting edge.
module seq_multiplier #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset,
  seq_multiplier_if.slave    bus,
  output logic [1:0]         state_dbg
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] product_q;
  logic [WIDTH:0]     sum;
  logic               accept;
  logic               last_iter;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_iter  = (count == CW'(WIDTH - 1));
    // The extra top bit keeps the carry so the shift below can move it into hi's MSB.
    sum        = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mcand     <= '0;
      hi        <= '0;
      lo        <= '0;
      count     <= '0;
      product_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        mcand <= bus.a;
        hi    <= '0;
        lo    <= bus.b;
        count <= '0;
      end else if (state == RUN) begin
        hi    <= sum[WIDTH:1];
        lo    <= {sum[0], lo[WIDTH-1:1]};
        count <= count + 1'b1;
        if (last_iter) product_q <= {sum[WIDTH:1], sum[0], lo[WIDTH-1:1]};
      end
    end
  end

  assign bus.busy    = (state == RUN);
  assign bus.done    = (state == DONE);
  assign bus.product = product_q;
  assign state_dbg   = state;
endmodule

// File: tb/tb_seq_multiplier.sv
// Randomized scoreboard bench for seq_multiplier: the driver pushes a*b and the cycle
// at which done is due, and the monitor checks busy/done/product on every falling edge.
module tb_seq_multiplier;
  localparam int W   = 64;
  localparam int P   = 2 * W;
  localparam int LAT = W;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] state_dbg;

  seq_multiplier_if #(.WIDTH(W)) bus ();

  seq_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock/reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [P-1:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [P-1:0] held = '0;
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic check(input string name, input logic [P-1:0] act, input logic [P-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // monitor
  logic m_has, m_done, m_busy;
  always @(negedge clk) begin
    if (reset) begin
      check("reset_busy", P'(bus.busy), '0);
      check("reset_done", P'(bus.done), '0);
      check("reset_product", bus.product, '0);
    end else begin
      m_has  = (exp_cyc_q.size() != 0);
      m_done = m_has && (cyc == exp_cyc_q[0]);
      m_busy = m_has && (cyc < exp_cyc_q[0]) && (cyc >= exp_cyc_q[0] - LAT);
      check("done", P'(bus.done), P'(m_done));
      check("busy", P'(bus.busy), P'(m_busy));
      if (m_done) begin
        check("product", bus.product, exp_q[0]);
        held = exp_q[0];
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end else begin
        check("product_hold", bus.product, held);
      end
    end
  end

  // driver tasks (called just after a rising edge)
  task automatic push_exp(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [P-1:0] xw;
    logic [P-1:0] yw;
    xw = P'(x);
    yw = P'(y);
    exp_q.push_back(xw * yw);
    exp_cyc_q.push_back(cyc + 1 + LAT);
  endtask

  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
    bus.start = 1'b1;
    bus.a     = x;
    bus.b     = y;
    push_exp(x, y);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = rnd64();
    bus.b     = rnd64();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3 * LAT && exp_cyc_q.size() != 0; k++) begin
      @(posedge clk); #1;
      bus.a = rnd64();
      bus.b = rnd64();
    end
    check("drain", P'(exp_cyc_q.size()), '0);
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  task automatic wait_cycle(input int target, input bit scramble);
    while (cyc < target) begin
      @(posedge clk); #1;
      if (scramble) begin
        bus.a = rnd64();
        bus.b = rnd64();
      end
    end
  endtask

  int           e;
  logic [W-1:0] x;
  logic [W-1:0] y;

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    start_op(64'd3, 64'd5);
    wait_idle();
    start_op('1, '1);
    wait_idle();
    start_op(64'h1234, 64'd0);
    wait_idle();
    start_op(64'd0, 64'hDEAD);
    wait_idle();

    // start mid-run must be ignored while operands keep changing
    e = cyc + 1;
    start_op(64'd7, 64'd6);
    wait_cycle(e + 10, 1'b1);
    bus.start = 1'b1;
    bus.a     = 64'd100;
    bus.b     = 64'd100;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle();

    // reset in the middle of an operation
    e = cyc + 1;
    start_op(64'd9, 64'd9);
    wait_cycle(e + 30, 1'b1);
    reset = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    held = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    start_op(64'd2, 64'd21);
    wait_idle();

    // back-to-back with start held high throughout
    e = cyc + 1;
    bus.start = 1'b1;
    bus.a     = 64'd10;
    bus.b     = 64'd10;
    push_exp(64'd10, 64'd10);
    @(posedge clk); #1;
    wait_cycle(e + LAT, 1'b0);
    bus.a = 64'd11;
    bus.b = 64'd11;
    push_exp(64'd11, 64'd11);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle();

    // random operands, mixing idle gaps and back-to-back starts
    for (int i = 0; i < 12; i++) begin
      x = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : rnd64();
      y = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : rnd64();
      if (($urandom_range(0, 1) == 1) && (exp_cyc_q.size() != 0)) begin
        wait_cycle(exp_cyc_q[$], 1'b1);
      end else begin
        wait_idle();
      end
      start_op(x, y);
    end
    wait_idle();
    repeat (5) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Iterative unsigned shift-add multiplier for the datapath's multi-cycle MUL path.
- Combinational gate-level logic computes bitwise results in a single pass. This block works the other way: it accumulates partial products serially, one operand bit per clock, behind a start/done handshake.
- Sits beside the ALU. Control logic asserts start with operands and stalls until done.

Parameters:
- WIDTH, 64, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on rising clk edge.
- a  input  WIDTH  multiplicand, unsigned; captured when start is accepted.
- b  input  WIDTH  multiplier, unsigned; captured when start is accepted.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; product valid.
- product  output  2*WIDTH  a*b; held until the next accepted start.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - reset is asynchronous and active-high.
  - While reset is high: state=IDLE, busy=0, done=0, product=0, iteration count=0, internal operand regs=0.
- State machine, states IDLE, RUN, DONE:
  - IDLE: start=1 at edge E -> latch a into multiplicand reg; load accumulator {hi=0, lo=b}; count=0; go to RUN. Otherwise stay.
  - RUN: one iteration per edge.
    - If acc lo bit 0 = 1, add the multiplicand to acc hi with WIDTH+1-bit carry.
    - Shift {carry, hi, lo} right by 1; count++.
    - After the WIDTH-th iteration (count reaches WIDTH), go to DONE.
  - DONE: lasts exactly one cycle.
    - start=1 -> accept new operands and go to RUN (back-to-back).
    - Otherwise go to IDLE.
- Outputs:
  - busy = 1 in RUN, else 0.
  - done = 1 in DONE only.
  - product = accumulator {hi, lo}. Update product only on the RUN->DONE edge; never update it mid-RUN.
- Latency:
  - start sampled at edge E -> busy high from E to E+WIDTH.
  - done high between edges E+WIDTH and E+WIDTH+1.
  - For WIDTH=64, done is 64 cycles after the accepting edge.
- Handshake rules:
  - start while in RUN is ignored. Operands are not re-latched, count is unaffected, no queueing.
  - a and b are don't-care except at the accepting edge. Changing them mid-RUN must not affect the result.
- Arithmetic:
  - Unsigned only. No overflow is possible: the full 2*WIDTH product is returned.
  - Carry out of the hi addition must be kept (WIDTH+1-bit adder) and shifted into the MSB.
- Boundary conditions:
  - a=0 or b=0 -> product=0, with the full WIDTH-cycle latency (no early exit).
  - Max operands: the carry path must not drop bit 2*WIDTH-1.
- Reset mid-operation: reset asserted in any state -> immediate return to reset values, no done pulse. The first start after reset release behaves as from IDLE.
- Simultaneous reset and start: reset wins.

Test Plan:
- Reset, then start with a=3, b=5 -> busy high 64 cycles; done pulse one cycle at edge E+64; product=15; done low next cycle; product stays 15.
- a=b=0xFFFF_FFFF_FFFF_FFFF -> product=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
- a=0x1234, b=0 and a=0, b=0xDEAD -> product=0 each, done still at E+64.
- Start a=7, b=6; at cycle 10 pulse start with a=100, b=100 and change a/b every cycle -> product=42 at E+64; no second done.
- Start a=9, b=9; assert reset at cycle 30 for 2 cycles -> busy=0, done=0, product=0 immediately; no done pulse. Then start a=2, b=21 -> product=42 after 64 cycles.
- Back-to-back: start held high continuously with a=10, b=10, then a=11, b=11 presented at the done cycle -> done pulses at E+64 (product=100) and E+129 (product=121); busy low only during each done cycle.
